// File: rtl/sram_responder.sv
// sram_responder: cycle-accurate 256Kx16 async SRAM pin-level model with byte lanes, read latency and statistics
module sram_responder #(
  parameter int          ADDR_W   = 18,
  parameter int          DEPTH    = 4096,
  parameter int          READ_LAT = 0,
  parameter logic [15:0] OOR_DATA = 16'hDEAD
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [15:0]       SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              oor_err,
  output logic              conflict_err
);
  localparam int IW = $clog2(DEPTH);
  logic [15:0] mem [DEPTH];
  logic        sel, wr, rd, in_rng, pend, q_v, q_ub, q_lb;
  logic [15:0] rd_word, q;
  assign sel     = !SRAM_CE_N;
  assign wr      = sel & !SRAM_WE_N;
  assign rd      = sel & SRAM_WE_N & !SRAM_OE_N;
  assign in_rng  = SRAM_ADDR < ADDR_W'(DEPTH);
  assign rd_word = in_rng ? mem[SRAM_ADDR[IW-1:0]] : OOR_DATA;
  always_ff @(posedge clk)
    if (wr && in_rng) begin
      if (!SRAM_UB_N) mem[SRAM_ADDR[IW-1:0]][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem[SRAM_ADDR[IW-1:0]][7:0] <= SRAM_DQ[7:0];
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_count     <= '0;
      wr_count     <= '0;
      oor_err      <= 1'b0;
      conflict_err <= 1'b0;
    end else begin
      if (rd && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if ((rd || wr) && !in_rng) oor_err <= 1'b1;
      if (wr && pend) conflict_err <= 1'b1;
    end
  if (READ_LAT == 0) begin : g_comb
    assign q    = rd_word;
    assign q_ub = !SRAM_UB_N;
    assign q_lb = !SRAM_LB_N;
    assign q_v  = rd;
    assign pend = 1'b0;
  end else begin : g_pipe
    // each stage carries {ub_en, lb_en, word}; valids reset, data does not
    logic [17:0]         st [READ_LAT];
    logic [READ_LAT-1:0] v;
    always_ff @(posedge clk or negedge rst)
      if (!rst) v <= '0;
      else v <= READ_LAT'({v, rd});
    always_ff @(posedge clk) begin
      st[0] <= {!SRAM_UB_N, !SRAM_LB_N, rd_word};
      for (int i = 1; i < READ_LAT; i++) st[i] <= st[i-1];
    end
    assign {q_ub, q_lb, q} = st[READ_LAT-1];
    assign pend = v[READ_LAT-1];
    assign q_v  = pend & sel & SRAM_WE_N & !SRAM_OE_N;
  end
  assign SRAM_DQ[15:8] = (q_v && q_ub && rst) ? q[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (q_v && q_lb && rst) ? q[7:0] : 8'hzz;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench; each latency variant sits on a pulled-up and a pulled-down bus to expose undriven lanes
module tb_sram_responder;
  logic        clk, rst, ce_n, we_n, oe_n, ub_n, lb_n, tb_oe;
  logic [17:0] addr;
  logic [15:0] tb_dq;
  int          cyc = 0, checks = 0, errors = 0;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
    logic [15:0] mask;
    string       name;
  } chk_t;
  chk_t sb[$];

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 3; g++) begin : ch
    localparam int LAT = (g == 0) ? 0 : g + 1;
    tri1 [15:0] u;
    tri0 [15:0] d;
    logic [15:0] rc, wc, rc_d, wc_d;
    logic        oe, cf, oe_d, cf_d;
    assign u = tb_oe ? tb_dq : 16'hzzzz;
    assign d = tb_oe ? tb_dq : 16'hzzzz;
    sram_responder #(.READ_LAT(LAT)) iu (
      .clk(clk), .rst(rst), .SRAM_DQ(u), .SRAM_ADDR(addr), .SRAM_WE_N(we_n),
      .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
      .rd_count(rc), .wr_count(wc), .oor_err(oe), .conflict_err(cf));
    sram_responder #(.READ_LAT(LAT)) id (
      .clk(clk), .rst(rst), .SRAM_DQ(d), .SRAM_ADDR(addr), .SRAM_WE_N(we_n),
      .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
      .rd_count(rc_d), .wr_count(wc_d), .oor_err(oe_d), .conflict_err(cf_d));
  end

  // upper half: lanes actually driven (pull-up and pull-down copies agree); lower half: driven data
  function automatic logic [31:0] dv(input logic [15:0] a, input logic [15:0] b);
    return {~(a ^ b), a & ~(a ^ b)};
  endfunction

  function automatic logic [31:0] act(input int k);
    case (k)
      0: return dv(ch[0].u, ch[0].d);
      1: return dv(ch[1].u, ch[1].d);
      2: return dv(ch[2].u, ch[2].d);
      3: return {~(ch[0].rc ^ ch[0].rc_d), ch[0].rc};
      4: return {~(ch[0].wc ^ ch[0].wc_d), ch[0].wc};
      5: return {~{16{ch[0].oe ^ ch[0].oe_d}}, 15'd0, ch[0].oe};
      6: return {~{16{ch[1].cf ^ ch[1].cf_d}}, 15'd0, ch[1].cf};
      7: return {~(ch[2].rc ^ ch[2].rc_d), ch[2].rc};
      8: return {~(ch[2].wc ^ ch[2].wc_d), ch[2].wc};
      default: return '0;
    endcase
  endfunction

  chk_t        e;
  logic [31:0] a, x;
  always @(negedge clk)
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      a = act(e.kind);
      x = {e.mask, e.exp & e.mask};
      checks++;
      if (a !== x || e.due != cyc) begin
        errors++;
        $display("FAIL %s: got drive %h data %h, want drive %h data %h", e.name, a[31:16], a[15:0], x[31:16], x[15:0]);
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, w, o, un, ln, input logic [17:0] ad, input logic t, input logic [15:0] v);
    ce_n = c; we_n = w; oe_n = o; ub_n = un; lb_n = ln; addr = ad; tb_oe = t; tb_dq = v;
  endtask

  task automatic chk(input int k, input logic [15:0] v, input logic [15:0] m, input string n);
    sb.push_back('{cyc, k, v, m, n});
  endtask

  task automatic idle(input int n);
    drive(1, 1, 1, 1, 1, 18'h0, 0, 16'h0);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [17:0] ad, input logic [15:0] v, input logic un, ln);
    drive(0, 0, 1, un, ln, ad, 1, v);
    tick();
  endtask

  task automatic rdx(input logic [17:0] ad, input logic un, ln, input int k, input logic [15:0] v, m, input string n);
    drive(0, 1, 0, un, ln, ad, 0, 16'h0);
    chk(k, v, m, n);
    tick();
  endtask

  initial begin
    rst = 0;
    idle(2);
    chk(3, 16'h0, 16'hFFFF, "rst_rd_count");
    chk(4, 16'h0, 16'hFFFF, "rst_wr_count");
    chk(5, 16'h0, 16'hFFFF, "rst_oor_err");
    chk(6, 16'h0, 16'hFFFF, "rst_conflict");
    chk(0, 16'h0, 16'h0, "rst_dq_lat0");
    chk(2, 16'h0, 16'h0, "rst_dq_lat3");
    tick();
    rst = 1;
    wr(18'h10, 16'h1234, 0, 0);
    rdx(18'h10, 0, 0, 0, 16'h1234, 16'hFFFF, "raw_0x10");
    drive(1, 1, 1, 1, 1, 18'h0, 0, 16'h0);
    chk(3, 16'd1, 16'hFFFF, "rd_count_1");
    chk(4, 16'd1, 16'hFFFF, "wr_count_1");
    tick();
    wr(18'h22, 16'h2222, 0, 0);
    wr(18'h23, 16'h3333, 0, 0);
    wr(18'h20, 16'hBABE, 0, 0);
    wr(18'h21, 16'hCAFE, 0, 0);
    drive(0, 0, 0, 0, 0, 18'h30, 0, 16'h0);
    chk(0, 16'h0, 16'h0, "write_dq_z");
    tick();
    rdx(18'h20, 0, 0, 0, 16'hBABE, 16'hFFFF, "burst_w0");
    rdx(18'h21, 0, 0, 0, 16'hCAFE, 16'hFFFF, "burst_w1");
    rdx(18'h22, 0, 0, 0, 16'h2222, 16'hFFFF, "burst_w2");
    rdx(18'h23, 0, 0, 0, 16'h3333, 16'hFFFF, "burst_w3");
    wr(18'h5, 16'hAAAA, 0, 0);
    wr(18'h5, 16'h1155, 1, 0);
    rdx(18'h5, 0, 0, 0, 16'hAA55, 16'hFFFF, "lane_merge");
    rdx(18'h5, 0, 1, 0, 16'hAA00, 16'hFF00, "lane_lb_off");
    wr(18'h0, 16'h0F0F, 0, 0);
    wr(18'd4096, 16'hFFFF, 0, 0);
    rdx(18'd4096, 0, 0, 0, 16'hDEAD, 16'hFFFF, "oor_read");
    chk(5, 16'h1, 16'hFFFF, "oor_err_set");
    rdx(18'h0, 0, 0, 0, 16'h0F0F, 16'hFFFF, "mem0_kept");
    drive(1, 1, 1, 1, 1, 18'h0, 0, 16'h0);
    rst = 0;
    chk(5, 16'h0, 16'hFFFF, "oor_err_clr");
    chk(3, 16'h0, 16'hFFFF, "rd_count_clr");
    tick();
    rst = 1;
    rdx(18'h0, 0, 0, 0, 16'h0F0F, 16'hFFFF, "mem0_after_rst");
    rdx(18'h10, 0, 0, 0, 16'h1234, 16'hFFFF, "mem10_after_rst");
    idle(3);
    wr(18'h1, 16'h0101, 0, 0);
    wr(18'h2, 16'h0202, 0, 0);
    drive(0, 1, 0, 0, 0, 18'h0, 0, 16'h0);
    chk(6, 16'h0, 16'hFFFF, "no_conflict_yet");
    tick();
    drive(0, 1, 0, 0, 0, 18'h1, 0, 16'h0);
    tick();
    rdx(18'h2, 0, 0, 1, 16'h0F0F, 16'hFFFF, "lat2_w0");
    rdx(18'h3, 0, 0, 1, 16'h0101, 16'hFFFF, "lat2_w1");
    drive(0, 0, 0, 1, 1, 18'h30, 0, 16'h0);
    chk(1, 16'h0, 16'h0, "conflict_dq_z");
    chk(6, 16'h0, 16'hFFFF, "conflict_pre");
    tick();
    drive(1, 1, 1, 1, 1, 18'h0, 0, 16'h0);
    chk(6, 16'h1, 16'hFFFF, "conflict_set");
    tick();
    drive(0, 0, 1, 1, 1, 18'h30, 0, 16'h0);
    repeat (65540) tick();
    drive(1, 1, 1, 1, 1, 18'h0, 0, 16'h0);
    chk(4, 16'hFFFF, 16'hFFFF, "wr_count_sat");
    idle(4);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 18'(i), 0, 16'h0);
      tick();
    end
    rdx(18'h3, 0, 0, 2, 16'h0F0F, 16'hFFFF, "lat3_w0");
    drive(0, 1, 0, 0, 0, 18'h4, 0, 16'h0);
    #1 rst = 0;
    chk(2, 16'h0, 16'h0, "rst_mid_read_z");
    chk(7, 16'h0, 16'hFFFF, "rst_mid_rd_count");
    chk(8, 16'h0, 16'hFFFF, "rst_mid_wr_count");
    tick();
    rst = 1;
    idle(3);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard: got %0d unchecked entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable, cycle-accurate model of the external 256Kx16 asynchronous SRAM chip.
- Acts as the responder on the SRAM pin interface (DQ, ADDR, WE_N, CE_N, OE_N, UB_N, LB_N) that the SRAM controller initiates.
- Used in simulation and on-FPGA loopback builds to exercise the controller without the physical chip.
- Provides byte-lane writes, configurable read latency, out-of-range detection and access statistics.

Parameters:
- ADDR_W, 18, SRAM address width.
- DEPTH, 4096, implemented words; addresses >= DEPTH are out of range.
- READ_LAT, 0, read latency in clocks. 0 = asynchronous (combinational) read like the real chip; 1..3 = registered pipeline for stress testing.
- OOR_DATA, 16'hDEAD, value returned for out-of-range reads.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- SRAM_DQ  inout  16  bidirectional data bus
- SRAM_ADDR  input  ADDR_W  word address
- SRAM_WE_N  input  1  write enable, active-low
- SRAM_CE_N  input  1  chip enable, active-low
- SRAM_OE_N  input  1  output enable, active-low
- SRAM_UB_N  input  1  upper byte [15:8] enable, active-low
- SRAM_LB_N  input  1  lower byte [7:0] enable, active-low
- rd_count  output  16  saturating count of read cycles
- wr_count  output  16  saturating count of write cycles
- oor_err  output  1  sticky: out-of-range access seen
- conflict_err  output  1  sticky: write issued while a registered read was due to drive the bus

Behaviour:
- Reset (rst=0, async): pipeline valids cleared, rd_count=0, wr_count=0, oor_err=0, conflict_err=0, DQ=Z. Memory array is not reset; contents persist across reset.
- sel = !CE_N.
- Write cycle: sel & !WE_N at posedge clk.
  - mem[ADDR][15:8] <= DQ[15:8] if !UB_N; mem[ADDR][7:0] <= DQ[7:0] if !LB_N.
  - wr_count+1 (saturates at 16'hFFFF).
  - A write with both UB_N=LB_N=1 still counts but changes nothing.
- Read cycle: sel & WE_N & !OE_N.
  - READ_LAT=0: DQ driven combinationally from mem[ADDR] in the same cycle. rd_count+1 at each posedge where the condition holds.
  - READ_LAT=N>0: address and lane enables captured at posedge into stage 1, shifted one stage per clock. rd_count+1 on capture. DQ driven from the stage-N word while stage N is valid, WE_N=1 and OE_N=0. The output stage holds its data until the next shift.
- Lane drive: lane [15:8] driven only if UB_N=0; lane [7:0] only if LB_N=0. Disabled lanes are Z. For READ_LAT>0, the lane enables used are those captured with the address.
- DQ is Z whenever WE_N=0, CE_N=1 or OE_N=1, or no valid output stage (READ_LAT>0). The model never drives DQ during a write.
- Out of range (ADDR >= DEPTH): write discarded; read returns OOR_DATA on the enabled lanes. oor_err set on the posedge and held until reset. Both still increment the counters.
- Simultaneous events:
  - WE_N=0 and OE_N=0 together: treated as a write; no read is captured.
  - READ_LAT>0 with stage N valid at a write posedge: conflict_err set, bus stays undriven, pipeline still shifts.
- Read-after-write to the same address on consecutive posedges returns the new data. With READ_LAT=0, DQ reflects the write in the cycle after the write edge.
- Reset mid-read: pipeline flushed, DQ goes Z asynchronously.

Test Plan:
- Reset released; WE_N=0 at ADDR=18'h10 with DQ=16'h1234 for one edge, then WE_N=1, OE_N=0 at 18'h10 -> DQ=16'h1234 combinationally (READ_LAT=0); wr_count=1, rd_count=1.
- Controller sequence: write 32'hCAFE_BABE at address 18'h20, then read 4 words from 18'h20 -> words 16'hBABE, 16'hCAFE, then old contents of 0x22 and 0x23; DQ=Z during the write cycles.
- Byte lanes: mem[5]=16'hAAAA, then write 16'h1155 with UB_N=1, LB_N=0 -> read 16'hAA55. Read with LB_N=1 -> DQ[7:0]=Z, DQ[15:8]=8'hAA.
- READ_LAT=2: reads issued on consecutive edges at 0,1,2 -> data appears 2 edges after each capture, back-to-back. WE_N=0 asserted while stage 2 is valid -> conflict_err=1 and DQ=Z.
- Out of range: ADDR=DEPTH, write 16'hFFFF then read -> DQ=16'hDEAD, oor_err=1, mem[0] unchanged. Deassert rst -> oor_err=0, mem contents retained.
- Saturation: 65 540 writes -> wr_count holds 16'hFFFF. Assert rst mid-read (READ_LAT=3) -> DQ=Z immediately, counters 0.
